// File: rtl/rs_arb_pkg.sv
// Shared types, widths and the round-robin search helper for the RS issue arbiter.
package rs_arb_pkg;

    localparam int unsigned RS_NUM_DEF = 4;
    localparam int unsigned RS_MAX     = 16;
    localparam int unsigned RS_MAX_W   = $clog2(RS_MAX);
    localparam int unsigned RS_IDX_W   = $clog2(RS_NUM_DEF);
    localparam int unsigned ALU_OP_W   = 3;

    typedef logic [RS_IDX_W-1:0] rs_idx_t;

    // One-hot of the first set bit of mask at or after ptr, wrapping within n stations.
    function automatic logic [RS_MAX-1:0] first_from(
        input logic [RS_MAX-1:0] mask,
        input int unsigned       ptr,
        input int unsigned       n
    );
        logic [RS_MAX-1:0] onehot;
        logic              found;
        int unsigned       idx;
        onehot = '0;
        found  = 1'b0;
        for (int unsigned k = 0; k < RS_MAX; k++) begin
            idx = ptr + k;
            if (idx >= n) idx = idx - n;
            if (k < n && idx < n && !found && mask[idx[RS_MAX_W-1:0]]) begin
                onehot[idx[RS_MAX_W-1:0]] = 1'b1;
                found = 1'b1;
            end
        end
        return onehot;
    endfunction

endpackage

// File: rtl/rs_issue_arbiter_rr_pick.sv
// Combinational round-robin picker: first set mask bit at or after ptr, as one-hot and index.
module rr_pick
    import rs_arb_pkg::*;
#(
    parameter int unsigned N = RS_NUM_DEF
) (
    input  logic [N-1:0]                     mask_i,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr_i,
    output logic [N-1:0]                     grant_o,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] idx_o
);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    logic [RS_MAX-1:0] pick_full;
    logic              unused_hi;

    assign pick_full = first_from(RS_MAX'(mask_i), 32'(ptr_i), N);
    assign grant_o   = pick_full[N-1:0];
    assign unused_hi = ^pick_full;

    always_comb begin
        idx_o = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant_o[i]) idx_o = IW'(i);
        end
    end

endmodule

// File: rtl/rs_issue_arbiter.sv
// Reservation-station allocator and round-robin issue arbiter feeding a registered FU issue stage.
// Optional RS_ARB_PERF_CNT_EN adds saturating transfer/stall counters.
module rs_issue_arbiter
    import rs_arb_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned TAG_WIDTH = 32,
    parameter int unsigned NUM_RS    = RS_NUM_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
`ifdef RS_ARB_PERF_CNT_EN
    output logic [31:0]                   perf_issue_cnt,
    output logic [31:0]                   perf_stall_cnt,
`endif
    input  logic                          alloc_req,
    output logic                          alloc_grant,
    output logic                          alloc_full,
    output logic [NUM_RS-1:0]             alloc_enable,
    input  logic [NUM_RS-1:0]             rs_busy,
    input  logic [NUM_RS-1:0]             rs_ready,
    input  logic [NUM_RS*XLEN-1:0]        rs_v1,
    input  logic [NUM_RS*XLEN-1:0]        rs_v2,
    input  logic [NUM_RS*ALU_OP_W-1:0]    rs_alu_op,
    input  logic [NUM_RS-1:0]             rs_alu_sign,
    input  logic [NUM_RS*TAG_WIDTH-1:0]   rs_rob_tag,
    output logic [NUM_RS-1:0]             rs_dispatched,
    input  logic                          fu_ready,
    output logic                          issue_valid,
    output logic [XLEN-1:0]               issue_v1,
    output logic [XLEN-1:0]               issue_v2,
    output logic [ALU_OP_W-1:0]           issue_alu_op,
    output logic                          issue_alu_sign,
    output logic [TAG_WIDTH-1:0]          issue_rob_tag
);
    localparam int unsigned PTR_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

    logic [NUM_RS-1:0]    issued_q, issued_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic                 valid_q, valid_d;
    logic [XLEN-1:0]      v1_q, v1_d, v2_q, v2_d;
    logic [ALU_OP_W-1:0]  op_q, op_d;
    logic                 sign_q, sign_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;

    logic [NUM_RS-1:0]    free, cand, grant_oh;
    logic [PTR_W-1:0]     grant_idx;
    logic                 can_load, grant_en;

    // A station still marked issued is not free, so allocation never hands out a stale entry.
    assign free         = ~rs_busy & ~issued_q;
    assign alloc_full   = ~|free;
    assign alloc_grant  = alloc_req & ~alloc_full;
    assign alloc_enable = alloc_req ? (free & (~free + NUM_RS'(1))) : '0;

    assign cand     = rs_ready & ~issued_q;
    assign can_load = ~valid_q | fu_ready;
    assign grant_en = can_load & (|cand) & ~flush;

    rr_pick #(.N(NUM_RS)) u_pick (
        .mask_i  (cand),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant_oh),
        .idx_o   (grant_idx)
    );

    always_comb begin
        issued_d = issued_q & rs_busy;
        rr_ptr_d = rr_ptr_q;
        valid_d  = valid_q;
        v1_d     = v1_q;
        v2_d     = v2_q;
        op_d     = op_q;
        sign_d   = sign_q;
        tag_d    = tag_q;
        if (flush) begin
            valid_d  = 1'b0;
            issued_d = '0;
        end else if (grant_en) begin
            valid_d  = 1'b1;
            issued_d = issued_d | grant_oh;
            v1_d     = rs_v1[32'(grant_idx)*XLEN +: XLEN];
            v2_d     = rs_v2[32'(grant_idx)*XLEN +: XLEN];
            op_d     = rs_alu_op[32'(grant_idx)*ALU_OP_W +: ALU_OP_W];
            sign_d   = rs_alu_sign[grant_idx];
            tag_d    = rs_rob_tag[32'(grant_idx)*TAG_WIDTH +: TAG_WIDTH];
            rr_ptr_d = (grant_idx == PTR_W'(NUM_RS-1)) ? '0 : grant_idx + PTR_W'(1);
        end else if (valid_q && fu_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issued_q <= '0;
            rr_ptr_q <= '0;
            valid_q  <= 1'b0;
            v1_q     <= '0;
            v2_q     <= '0;
            op_q     <= '0;
            sign_q   <= 1'b0;
            tag_q    <= '0;
        end else begin
            issued_q <= issued_d;
            rr_ptr_q <= rr_ptr_d;
            valid_q  <= valid_d;
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            op_q     <= op_d;
            sign_q   <= sign_d;
            tag_q    <= tag_d;
        end
    end

    assign rs_dispatched  = issued_q;
    assign issue_valid    = valid_q;
    assign issue_v1       = v1_q;
    assign issue_v2       = v2_q;
    assign issue_alu_op   = op_q;
    assign issue_alu_sign = sign_q;
    assign issue_rob_tag  = tag_q;

`ifdef RS_ARB_PERF_CNT_EN
    logic [31:0] perf_issue_q, perf_issue_d, perf_stall_q, perf_stall_d;

    // Saturating counters, untouched by flush.
    always_comb begin
        perf_issue_d = perf_issue_q;
        perf_stall_d = perf_stall_q;
        if (valid_q && fu_ready && perf_issue_q != '1)  perf_issue_d = perf_issue_q + 32'd1;
        if (valid_q && !fu_ready && perf_stall_q != '1) perf_stall_d = perf_stall_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_issue_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_issue_q <= perf_issue_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_issue_cnt = perf_issue_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_rs_issue_arbiter.sv
// Randomized self-checking bench for rs_issue_arbiter against a behavioural station/issue model.
module tb_rs_issue_arbiter;
    localparam int N  = 4;
    localparam int XL = 32;
    localparam int TW = 32;

    logic              clk = 1'b0;
    logic              reset, flush, alloc_req, fu_ready;
    logic              alloc_grant, alloc_full;
    logic [N-1:0]      alloc_enable, rs_busy, rs_ready, rs_alu_sign, rs_dispatched;
    logic [N*XL-1:0]   rs_v1, rs_v2;
    logic [N*3-1:0]    rs_alu_op;
    logic [N*TW-1:0]   rs_rob_tag;
    logic              issue_valid, issue_alu_sign;
    logic [XL-1:0]     issue_v1, issue_v2;
    logic [2:0]        issue_alu_op;
    logic [TW-1:0]     issue_rob_tag;
`ifdef RS_ARB_PERF_CNT_EN
    logic [31:0]       perf_issue_cnt, perf_stall_cnt;
`endif

    rs_issue_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
`ifdef RS_ARB_PERF_CNT_EN
        .perf_issue_cnt (perf_issue_cnt),
        .perf_stall_cnt (perf_stall_cnt),
`endif
        .alloc_req      (alloc_req),
        .alloc_grant    (alloc_grant),
        .alloc_full     (alloc_full),
        .alloc_enable   (alloc_enable),
        .rs_busy        (rs_busy),
        .rs_ready       (rs_ready),
        .rs_v1          (rs_v1),
        .rs_v2          (rs_v2),
        .rs_alu_op      (rs_alu_op),
        .rs_alu_sign    (rs_alu_sign),
        .rs_rob_tag     (rs_rob_tag),
        .rs_dispatched  (rs_dispatched),
        .fu_ready       (fu_ready),
        .issue_valid    (issue_valid),
        .issue_v1       (issue_v1),
        .issue_v2       (issue_v2),
        .issue_alu_op   (issue_alu_op),
        .issue_alu_sign (issue_alu_sign),
        .issue_rob_tag  (issue_rob_tag)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Station contents presented this cycle
    logic [XL-1:0] st_v1 [N];
    logic [XL-1:0] st_v2 [N];
    logic [TW-1:0] st_tag[N];
    logic [2:0]    st_op [N];
    logic          st_sign[N];

    // Reference model state
    bit            m_issued[N];
    int            m_ptr;
    bit            m_valid;
    logic [XL-1:0] m_v1, m_v2;
    logic [TW-1:0] m_tag;
    logic [2:0]    m_op;
    logic          m_sign;
    longint        m_pi, m_ps;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_issued[i] = 1'b0;
        m_ptr = 0; m_valid = 1'b0;
        m_v1 = '0; m_v2 = '0; m_tag = '0; m_op = '0; m_sign = 1'b0;
        m_pi = 0; m_ps = 0;
    endtask

    task automatic drive(input logic [N-1:0] busy, input logic [N-1:0] ready,
                         input logic fr, input logic fl, input logic ar);
        rs_busy = busy; rs_ready = ready; fu_ready = fr; flush = fl; alloc_req = ar;
        for (int i = 0; i < N; i++) begin
            st_v1[i] = $urandom; st_v2[i] = $urandom; st_tag[i] = $urandom;
            st_op[i] = 3'($urandom); st_sign[i] = 1'($urandom);
            rs_v1[i*XL +: XL] = st_v1[i];
            rs_v2[i*XL +: XL] = st_v2[i];
            rs_rob_tag[i*TW +: TW] = st_tag[i];
            rs_alu_op[i*3 +: 3] = st_op[i];
            rs_alu_sign[i] = st_sign[i];
        end
    endtask

    // Compare all outputs with the model, then advance the model across one clock edge.
    task automatic check_and_advance();
        logic [N-1:0] exp_en, exp_disp;
        bit any_free;
        int low, g, idx;
        #1;
        any_free = 1'b0; low = -1; exp_en = '0;
        for (int i = 0; i < N; i++) begin
            exp_disp[i] = m_issued[i];
            if (!rs_busy[i] && !m_issued[i]) begin
                any_free = 1'b1;
                if (low < 0) low = i;
            end
        end
        if (alloc_req && any_free) exp_en[low] = 1'b1;
        chk("alloc_enable",  64'(alloc_enable),  64'(exp_en));
        chk("alloc_grant",   64'(alloc_grant),   64'(alloc_req && any_free));
        chk("alloc_full",    64'(alloc_full),    64'(!any_free));
        chk("rs_dispatched", 64'(rs_dispatched), 64'(exp_disp));
        chk("issue_valid",   64'(issue_valid),   64'(m_valid));
        chk("issue_v1",      64'(issue_v1),      64'(m_v1));
        chk("issue_v2",      64'(issue_v2),      64'(m_v2));
        chk("issue_op",      64'(issue_alu_op),  64'(m_op));
        chk("issue_sign",    64'(issue_alu_sign), 64'(m_sign));
        chk("issue_tag",     64'(issue_rob_tag), 64'(m_tag));
`ifdef RS_ARB_PERF_CNT_EN
        chk("perf_issue",    64'(perf_issue_cnt), 64'(m_pi));
        chk("perf_stall",    64'(perf_stall_cnt), 64'(m_ps));
`endif
        g = -1;
        if ((!m_valid || fu_ready) && !flush) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (g < 0 && rs_ready[idx] && !m_issued[idx]) g = idx;
            end
        end
        if (m_valid && fu_ready && m_pi < 64'hFFFF_FFFF) m_pi++;
        if (m_valid && !fu_ready && m_ps < 64'hFFFF_FFFF) m_ps++;
        for (int i = 0; i < N; i++) if (m_issued[i] && !rs_busy[i]) m_issued[i] = 1'b0;
        if (flush) begin
            m_valid = 1'b0;
            for (int i = 0; i < N; i++) m_issued[i] = 1'b0;
        end else if (g >= 0) begin
            m_valid = 1'b1;
            m_v1 = st_v1[g]; m_v2 = st_v2[g]; m_tag = st_tag[g];
            m_op = st_op[g]; m_sign = st_sign[g];
            m_issued[g] = 1'b1;
            m_ptr = (g + 1) % N;
        end else if (m_valid && fu_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [N-1:0] busy, input logic [N-1:0] ready,
                        input logic fr, input logic fl, input logic ar);
        drive(busy, ready, fr, fl, ar);
        check_and_advance();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #1;
        chk("async_rst_valid", 64'(issue_valid), 64'(0));
        chk("async_rst_disp",  64'(rs_dispatched), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [N-1:0] busy, ready;
        reset = 1'b1;
        drive(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(issue_valid), 64'(0));
        chk("rst_disp",  64'(rs_dispatched), 64'(0));
        reset = 1'b0;

        // First edge after reset grants RS0
        check_and_advance();
        chk("first_valid", 64'(issue_valid), 64'(1));
        chk("first_tag",   64'(issue_rob_tag), 64'(st_tag[0]));

        // Back-to-back round-robin with stations freeing as they issue
        repeat (4) step(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0);
        repeat (4) step(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1);
        repeat (5) step(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0);

        // Stall then release
        repeat (3) step(4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0);
        step(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0);

        // Allocation boundaries
        step(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1);
        step(4'b1011, 4'b0000, 1'b1, 1'b0, 1'b1);
        step(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1);
        step(4'b1011, 4'b0000, 1'b1, 1'b0, 1'b1);

        // Flush with live issue stage
        step(4'b0101, 4'b0101, 1'b0, 1'b0, 1'b0);
        step(4'b0101, 4'b0101, 1'b0, 1'b1, 1'b0);
        step(4'b0101, 4'b0000, 1'b0, 1'b0, 1'b1);

        // Randomized traffic with occasional flush and reset
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(99) == 0) begin
                do_reset();
            end else begin
                busy  = N'($urandom | $urandom);
                ready = busy & N'($urandom);
                step(busy, ready, 1'($urandom_range(3) != 0),
                     1'($urandom_range(24) == 0), 1'($urandom));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
